// File: rtl/m_parity_rx.sv
// Serial receiver for the XOR-parity link: start bit, DATA_W data bits LSB-first, parity bit.
// The received word is held in an output register with a valid/ready handshake and a sticky overrun flag.
module m_parity_rx #(
    parameter int DATA_W     = 16,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_data,
    output logic              o_parity_err,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY
    } state_t;

    state_t              state_reg,   state_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic                acc_reg,     acc_next;
    logic [DATA_W-1:0]   shift_reg,   shift_next;
    logic [DATA_W-1:0]   data_reg,    data_next;
    logic                err_reg,     err_next;
    logic                valid_reg,   valid_next;
    logic                overrun_reg, overrun_next;

    logic                shift_wr;
    logic                frame_done;
    logic                frame_err;

    // Each shift-register bit captures the line only when the counter points at it.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            assign shift_next[gi] = (shift_wr && (cnt_reg == CNT_W'(gi))) ? i_bit : shift_reg[gi];
        end
    endgenerate

    assign frame_err = ((acc_reg ^ i_bit) != ODD_PARITY);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        shift_wr   = 1'b0;
        frame_done = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_bit_valid && !i_bit) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                    acc_next   = 1'b0;
                end
            end
            ST_DATA: begin
                if (i_bit_valid) begin
                    shift_wr = 1'b1;
                    acc_next = acc_reg ^ i_bit;
                    // Counter parks at the last index rather than wrapping.
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_PARITY;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (i_bit_valid) begin
                    frame_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_next    = data_reg;
        err_next     = err_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;

        if (frame_done) begin
            // A consumer taking the old word this cycle frees the register for the new one.
            if (!valid_reg || i_ready) begin
                data_next  = shift_reg;
                err_next   = frame_err;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && i_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= 1'b0;
            shift_reg   <= '0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            err_reg     <= err_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign o_data       = data_reg;
    assign o_parity_err = err_reg;
    assign o_valid      = valid_reg;
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_m_parity_rx.sv
// Directed bench for m_parity_rx: an even-parity and an odd-parity instance share one stimulus stream.
module tb_m_parity_rx;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_bit_valid = 1'b0;
    logic        i_bit = 1'b1;
    logic        i_ready = 1'b0;

    logic [15:0] o_data;
    logic        o_parity_err, o_valid, o_busy, o_overrun;
    logic [15:0] odd_data;
    logic        odd_parity_err, odd_valid, odd_busy, odd_overrun;

    int n_checks = 0;
    int n_errors = 0;

    m_parity_rx #(.DATA_W(16), .ODD_PARITY(1'b0)) dut_even (
        .i_clk(i_clk), .i_rst(i_rst), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
        .o_data(o_data), .o_parity_err(o_parity_err), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    m_parity_rx #(.DATA_W(16), .ODD_PARITY(1'b1)) dut_odd (
        .i_clk(i_clk), .i_rst(i_rst), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
        .o_data(odd_data), .o_parity_err(odd_parity_err), .o_valid(odd_valid),
        .i_ready(i_ready), .o_busy(odd_busy), .o_overrun(odd_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_bit_valid = 1'b1;
        i_bit       = b;
        tick();
        i_bit_valid = 1'b0;
        i_bit       = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    // Start bit plus data bits; busy_ok records whether o_busy stayed high throughout.
    task automatic send_head(input logic [15:0] w, input int max_gap, output logic busy_ok);
        busy_ok = 1'b1;
        send_bit(1'b0);
        busy_ok &= (o_busy === 1'b1);
        for (int i = 0; i < 16; i++) begin
            gap($urandom_range(max_gap, 0));
            busy_ok &= (o_busy === 1'b1);
            send_bit(w[i]);
            busy_ok &= (o_busy === 1'b1);
        end
        gap($urandom_range(max_gap, 0));
        busy_ok &= (o_busy === 1'b1);
    endtask

    task automatic send_frame(input logic [15:0] w, input logic par, input int max_gap,
                              output logic busy_ok);
        send_head(w, max_gap, busy_ok);
        send_bit(par);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        gap(3);
        n_checks++; if (o_data !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %h expected 0000", o_data); end
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
        n_checks++; if (o_parity_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", o_parity_err); end
        #3 i_rst = 1'b0;
        tick();
        $display("test_reset: data=%h valid=%b busy=%b overrun=%b", o_data, o_valid, o_busy, o_overrun);
    endtask

    task automatic test_even_basic();
        logic busy_ok;
        i_ready = 1'b1;
        send_head(16'h00A5, 0, busy_ok);
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL t1_valid_early: got %b expected 0", o_valid); end
        send_bit(1'b0);
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t1_valid: got %b expected 1", o_valid); end
        n_checks++; if (o_data !== 16'h00A5) begin n_errors++; $display("FAIL t1_data: got %h expected 00a5", o_data); end
        n_checks++; if (o_parity_err !== 1'b0) begin n_errors++; $display("FAIL t1_err: got %b expected 0", o_parity_err); end
        n_checks++; if (odd_parity_err !== 1'b1) begin n_errors++; $display("FAIL t1_odd_err: got %b expected 1", odd_parity_err); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL t1_valid_drop: got %b expected 0", o_valid); end
        n_checks++; if (o_data !== 16'h00A5) begin n_errors++; $display("FAIL t1_data_hold: got %h expected 00a5", o_data); end
        $display("test_even_basic: data=%h err=%b odd_err=%b", o_data, o_parity_err, odd_parity_err);
    endtask

    task automatic test_parity_err();
        logic busy_ok;
        i_ready = 1'b1;
        send_frame(16'h00A5, 1'b1, 0, busy_ok);
        n_checks++; if (o_data !== 16'h00A5) begin n_errors++; $display("FAIL t2_data: got %h expected 00a5", o_data); end
        n_checks++; if (o_parity_err !== 1'b1) begin n_errors++; $display("FAIL t2_err: got %b expected 1", o_parity_err); end
        n_checks++; if (odd_data !== 16'h00A5) begin n_errors++; $display("FAIL t2_odd_data: got %h expected 00a5", odd_data); end
        n_checks++; if (odd_parity_err !== 1'b0) begin n_errors++; $display("FAIL t2_odd_err: got %b expected 0", odd_parity_err); end
        tick();
        $display("test_parity_err: data=%h err=%b odd_err=%b", o_data, o_parity_err, odd_parity_err);
    endtask

    task automatic test_gaps_busy();
        logic busy_ok;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL t3_idle_busy: got %b expected 0", o_busy); end
        end
        send_frame(16'hFFFF, 1'b0, 3, busy_ok);
        n_checks++; if (busy_ok !== 1'b1) begin n_errors++; $display("FAIL t3_busy_in_frame: got %b expected 1", busy_ok); end
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL t3_busy_after: got %b expected 0", o_busy); end
        n_checks++; if (o_data !== 16'hFFFF) begin n_errors++; $display("FAIL t3_data: got %h expected ffff", o_data); end
        n_checks++; if (o_parity_err !== 1'b0) begin n_errors++; $display("FAIL t3_err: got %b expected 0", o_parity_err); end
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t3_valid: got %b expected 1", o_valid); end
        tick();
        $display("test_gaps_busy: data=%h err=%b busy_ok=%b", o_data, o_parity_err, busy_ok);
    endtask

    task automatic test_overrun();
        logic busy_ok;
        i_ready = 1'b0;
        send_frame(16'h1234, 1'b1, 0, busy_ok);
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t4_valid1: got %b expected 1", o_valid); end
        n_checks++; if (o_data !== 16'h1234) begin n_errors++; $display("FAIL t4_data1: got %h expected 1234", o_data); end
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL t4_overrun_pre: got %b expected 0", o_overrun); end
        send_frame(16'hBEEF, 1'b1, 1, busy_ok);
        n_checks++; if (o_data !== 16'h1234) begin n_errors++; $display("FAIL t4_data_kept: got %h expected 1234", o_data); end
        n_checks++; if (o_overrun !== 1'b1) begin n_errors++; $display("FAIL t4_overrun: got %b expected 1", o_overrun); end
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t4_valid2: got %b expected 1", o_valid); end
        gap(3);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL t4_valid_drop: got %b expected 0", o_valid); end
        n_checks++; if (o_overrun !== 1'b1) begin n_errors++; $display("FAIL t4_overrun_sticky: got %b expected 1", o_overrun); end
        n_checks++; if (o_data !== 16'h1234) begin n_errors++; $display("FAIL t4_data_hold: got %h expected 1234", o_data); end
        $display("test_overrun: data=%h valid=%b overrun=%b", o_data, o_valid, o_overrun);
    endtask

    task automatic test_back_to_back();
        logic busy_ok;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL t5_overrun_clr: got %b expected 0", o_overrun); end
        i_ready = 1'b0;
        send_frame(16'h1234, 1'b1, 0, busy_ok);
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t5_valid1: got %b expected 1", o_valid); end
        send_head(16'h5678, 0, busy_ok);
        i_ready = 1'b1;
        send_bit(1'b0);
        n_checks++; if (o_data !== 16'h5678) begin n_errors++; $display("FAIL t5_data: got %h expected 5678", o_data); end
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t5_valid2: got %b expected 1", o_valid); end
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL t5_overrun: got %b expected 0", o_overrun); end
        n_checks++; if (o_parity_err !== 1'b0) begin n_errors++; $display("FAIL t5_err: got %b expected 0", o_parity_err); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL t5_valid_drop: got %b expected 0", o_valid); end
        i_ready = 1'b0;
        $display("test_back_to_back: data=%h valid=%b overrun=%b", o_data, o_valid, o_overrun);
    endtask

    task automatic test_reset_midframe();
        logic busy_ok;
        i_ready = 1'b0;
        send_frame(16'h1234, 1'b1, 0, busy_ok);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL t6_busy_pre: got %b expected 1", o_busy); end
        #3 i_rst = 1'b1;
        #1;
        n_checks++; if (o_data !== 16'h0000) begin n_errors++; $display("FAIL t6_data: got %h expected 0000", o_data); end
        n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL t6_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL t6_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_parity_err !== 1'b0) begin n_errors++; $display("FAIL t6_err: got %b expected 0", o_parity_err); end
        n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL t6_overrun: got %b expected 0", o_overrun); end
        tick();
        #3 i_rst = 1'b0;
        tick();
        i_ready = 1'b1;
        send_frame(16'h0F0F, 1'b0, 0, busy_ok);
        n_checks++; if (o_data !== 16'h0F0F) begin n_errors++; $display("FAIL t6_data_after: got %h expected 0f0f", o_data); end
        n_checks++; if (o_parity_err !== 1'b0) begin n_errors++; $display("FAIL t6_err_after: got %b expected 0", o_parity_err); end
        n_checks++; if (o_valid !== 1'b1) begin n_errors++; $display("FAIL t6_valid_after: got %b expected 1", o_valid); end
        tick();
        $display("test_reset_midframe: data=%h err=%b", o_data, o_parity_err);
    endtask

    initial begin
        test_reset();
        test_even_basic();
        test_parity_err();
        test_gaps_busy();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
